// File: rtl/furv_dmem.sv
// Word-addressed data memory for the furv load/store port. Every access takes WAIT_STATES+1 cycles,
// and ready is high in the last cycle only. Define FURV_DMEM_MMIO_EN to add the CYCLES/GPIO window.
module furv_dmem #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem,
  input  logic        mem_read,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  output logic        ready,
  output logic        err,
  output logic [31:0] gpio_out
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] ram [DEPTH];

  logic          misaligned, in_ram, is_cyc, is_gpio, bad;
  logic [AW-1:0] idx;
  logic [31:0]   rdata, mmio_rdata;

  assign misaligned = addr[1:0] != 2'b00;
  assign in_ram     = addr < RAM_BYTES;
  assign idx        = addr[2 +: AW];
  assign bad        = misaligned || !(in_ram || is_cyc || is_gpio);

  assign ready = !rst && mem &&
                 ((state == IDLE && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd0));

`ifdef FURV_DMEM_MMIO_EN
  logic [31:0] cycles, gpio_q;

  assign is_cyc     = addr == 32'hFFFF_FFF0;
  assign is_gpio    = addr == 32'hFFFF_FFF4;
  assign mmio_rdata = is_cyc ? cycles : gpio_q;
  assign gpio_out   = gpio_q;

  // Stores to CYCLES are accepted silently; only GPIO is writable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
      gpio_q <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (ready && !mem_read && is_gpio) gpio_q <= data;
    end
  end
`else
  assign is_cyc     = 1'b0;
  assign is_gpio    = 1'b0;
  assign mmio_rdata = '0;
  assign gpio_out   = '0;
`endif

  always_comb begin
    rdata = '0;
    if (!bad) rdata = in_ram ? ram[idx] : mmio_rdata;
  end

  assign data = (mem && mem_read && !rst) ? rdata : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem && !ready) begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          // Dropping mem mid-count abandons the access without side effects.
          if (!mem)               state <= IDLE;
          else if (cnt != 4'd0)   cnt   <= cnt - 4'd1;
          else                    state <= IDLE;
        end
      endcase
      if (ready && bad) err <= 1'b1;
    end
  end

  // ready already masks rst, so a store cut short by reset never lands here.
  always_ff @(posedge clk) begin
    if (ready && !mem_read && in_ram && !misaligned) ram[idx] <= data;
  end

endmodule

// File: tb/tb_furv_dmem.sv
module tb_furv_dmem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r  [2];
  logic        rd_r   [2];
  logic [31:0] addr_r [2];
  logic [31:0] wdat_r [2];
  wire  [31:0] data0, data3;
  logic        rdy0, rdy3, err0, err3;
  logic [31:0] gpio0, gpio3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [2][64];
  logic        exp_err [2];

  always #5 clk = ~clk;

  assign data0 = (mem_r[0] && !rd_r[0]) ? wdat_r[0] : 'z;
  assign data3 = (mem_r[1] && !rd_r[1]) ? wdat_r[1] : 'z;

  furv_dmem #(.DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .mem(mem_r[0]), .mem_read(rd_r[0]), .addr(addr_r[0]),
    .data(data0), .ready(rdy0), .err(err0), .gpio_out(gpio0));

  furv_dmem #(.DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .mem(mem_r[1]), .mem_read(rd_r[1]), .addr(addr_r[1]),
    .data(data3), .ready(rdy3), .err(err3), .gpio_out(gpio3));

  function automatic int ws(int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic get_rdy(int i);
    return (i == 0) ? rdy0 : rdy3;
  endfunction

  function automatic logic [31:0] get_data(int i);
    return (i == 0) ? data0 : data3;
  endfunction

  function automatic logic get_err(int i);
    return (i == 0) ? err0 : err3;
  endfunction

  // Reference decode: 64-word RAM, optional MMIO pair, everything else is an error.
  function automatic bit model_bad(logic [31:0] a);
    bit mmio = 1'b0;
`ifdef FURV_DMEM_MMIO_EN
    mmio = (a == 32'hFFFF_FFF0) || (a == 32'hFFFF_FFF4);
`endif
    return (a[1:0] != 2'b00) || (!mmio && a >= 32'd256);
  endfunction

  // Drives one request and holds it until ready; rcyc is the cycle index of ready, -1 on timeout.
  task automatic do_access(input int i, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                           output int rcyc, output logic [31:0] rv);
    rcyc = -1;
    rv   = '0;
    mem_r[i] = 1'b1; rd_r[i] = rd; addr_r[i] = a; wdat_r[i] = wd;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (get_rdy(i)) begin
        rcyc = c;
        rv   = get_data(i);
      end
      @(posedge clk); #1;
      if (rcyc >= 0) break;
    end
    mem_r[i] = 1'b0; rd_r[i] = 1'b0;
    if (model_bad(a)) exp_err[i] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_r[0] = 1'b1; rd_r[0] = 1'b1; addr_r[0] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy0: got %b exp 0", rdy0); end
    n_tests++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy3: got %b exp 0", rdy3); end
    n_tests++; if (err0 !== 1'b0 || err3 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b/%b exp 0/0", err0, err3); end
    n_tests++; if (gpio0 !== 32'h0) begin n_fail++; $display("FAIL reset_gpio: got %h exp 0", gpio0); end
    n_tests++; if (!(data0 === 32'bz || data0 === 32'h0)) begin n_fail++; $display("FAIL reset_hiz: got %h exp z", data0); end
    @(posedge clk); #1;
    mem_r[0] = 1'b0; rd_r[0] = 1'b0;
    rst = 1'b0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
  endtask

  task automatic test_fill();
    int rc; logic [31:0] rv, v;
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 64; w++) begin
        v = $urandom;
        do_access(i, 1'b0, 32'(w * 4), v, rc, rv);
        ref_mem[i][w] = v;
        n_tests++; if (rc !== ws(i)) begin n_fail++; $display("FAIL fill_latency[%0d]: got %0d exp %0d", i, rc, ws(i)); end
      end
    end
  endtask

  task automatic test_single_cycle();
    int rc; logic [31:0] rv;
    do_access(0, 1'b0, 32'h10, 32'hDEADBEEF, rc, rv);
    ref_mem[0][4] = 32'hDEADBEEF;
    n_tests++; if (rc !== 0) begin n_fail++; $display("FAIL single_store_rdy: got %0d exp 0", rc); end
    do_access(0, 1'b1, 32'h10, 32'h0, rc, rv);
    n_tests++; if (rc !== 0) begin n_fail++; $display("FAIL single_load_rdy: got %0d exp 0", rc); end
    n_tests++; if (rv !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_load_data: got %h exp deadbeef", rv); end
    n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b exp 0", err0); end
  endtask

  task automatic test_wait_states();
    int rc; logic [31:0] rv, v;
    do_access(1, 1'b1, 32'h20, 32'h0, rc, rv);
    n_tests++; if (rc !== 3) begin n_fail++; $display("FAIL wait_load_rdy: got %0d exp 3", rc); end
    n_tests++; if (rv !== ref_mem[1][8]) begin n_fail++; $display("FAIL wait_load_data: got %h exp %h", rv, ref_mem[1][8]); end
    v = ~ref_mem[1][8];
    do_access(1, 1'b0, 32'h20, v, rc, rv);
    ref_mem[1][8] = v;
    n_tests++; if (rc !== 3) begin n_fail++; $display("FAIL wait_store_rdy: got %0d exp 3", rc); end
    do_access(1, 1'b1, 32'h20, 32'h0, rc, rv);
    n_tests++; if (rv !== v) begin n_fail++; $display("FAIL wait_readback: got %h exp %h", rv, v); end
  endtask

  task automatic test_abort();
    int rc; logic [31:0] rv;
    mem_r[1] = 1'b1; rd_r[1] = 1'b0; addr_r[1] = 32'h30; wdat_r[1] = 32'h5;
    @(negedge clk);
    n_tests++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL abort_rdy: got %b exp 0", rdy3); end
    @(posedge clk); #1;
    mem_r[1] = 1'b0;
    @(posedge clk); #1;
    do_access(1, 1'b1, 32'h30, 32'h0, rc, rv);
    n_tests++; if (rc !== 3) begin n_fail++; $display("FAIL abort_idle_latency: got %0d exp 3", rc); end
    n_tests++; if (rv !== ref_mem[1][12]) begin n_fail++; $display("FAIL abort_old_value: got %h exp %h", rv, ref_mem[1][12]); end
    n_tests++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b exp 0", err3); end
  endtask

  task automatic test_random();
    int rc, i, w; bit rd; logic [31:0] rv, v;
    for (int k = 0; k < 80; k++) begin
      i  = int'($urandom_range(0, 1));
      w  = int'($urandom_range(0, 63));
      rd = 1'($urandom);
      v  = $urandom;
      do_access(i, rd, 32'(w * 4), v, rc, rv);
      n_tests++; if (rc !== ws(i)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d exp %0d", i, rc, ws(i)); end
      if (rd) begin
        n_tests++; if (rv !== ref_mem[i][w]) begin n_fail++; $display("FAIL rand_load[%0d] w%0d: got %h exp %h", i, w, rv, ref_mem[i][w]); end
      end else begin
        ref_mem[i][w] = v;
      end
    end
    n_tests++; if (err0 !== 1'b0 || err3 !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b/%b exp 0/0", err0, err3); end
  endtask

  task automatic test_mmio();
    int rc, n; logic [31:0] rv, c1, c2;
    do_access(0, 1'b0, 32'hFFFF_FFF4, 32'hA5, rc, rv);
`ifdef FURV_DMEM_MMIO_EN
    n_tests++; if (gpio0 !== 32'hA5) begin n_fail++; $display("FAIL mmio_gpio: got %h exp a5", gpio0); end
    n_tests++; if (gpio3 !== 32'h0) begin n_fail++; $display("FAIL mmio_gpio_other: got %h exp 0", gpio3); end
    do_access(0, 1'b1, 32'hFFFF_FFF4, 32'h0, rc, rv);
    n_tests++; if (rv !== 32'hA5) begin n_fail++; $display("FAIL mmio_gpio_load: got %h exp a5", rv); end
    do_access(0, 1'b0, 32'hFFFF_FFF0, 32'h1234, rc, rv);
    n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL mmio_cycles_store_err: got %b exp 0", err0); end
    do_access(0, 1'b1, 32'hFFFF_FFF0, 32'h0, rc, c1);
    n = int'($urandom_range(3, 30));
    repeat (n) @(posedge clk);
    #1;
    do_access(0, 1'b1, 32'hFFFF_FFF0, 32'h0, rc, c2);
    n_tests++; if (c2 - c1 !== 32'(n + 1)) begin n_fail++; $display("FAIL mmio_cycles_delta: got %0d exp %0d", c2 - c1, n + 1); end
`else
    n_tests++; if (gpio0 !== 32'h0) begin n_fail++; $display("FAIL nommio_gpio: got %h exp 0", gpio0); end
    do_access(0, 1'b1, 32'hFFFF_FFF0, 32'h0, rc, rv);
    n_tests++; if (rv !== 32'h0) begin n_fail++; $display("FAIL nommio_load: got %h exp 0", rv); end
    n_tests++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL nommio_err: got %b exp 1", err0); end
`endif
  endtask

  task automatic test_errors();
    int rc; logic [31:0] rv;
    for (int i = 0; i < 2; i++) begin
      do_access(i, 1'b1, 32'h13, 32'h0, rc, rv);
      n_tests++; if (rc !== ws(i)) begin n_fail++; $display("FAIL err_misalign_rdy[%0d]: got %0d exp %0d", i, rc, ws(i)); end
      n_tests++; if (rv !== 32'h0) begin n_fail++; $display("FAIL err_misalign_data[%0d]: got %h exp 0", i, rv); end
      n_tests++; if (get_err(i) !== 1'b1) begin n_fail++; $display("FAIL err_misalign_flag[%0d]: got %b exp 1", i, get_err(i)); end
      do_access(i, 1'b0, 32'h100, $urandom, rc, rv);
      n_tests++; if (rc !== ws(i)) begin n_fail++; $display("FAIL err_unmapped_rdy[%0d]: got %0d exp %0d", i, rc, ws(i)); end
      do_access(i, 1'b0, 32'h12, $urandom, rc, rv);
      do_access(i, 1'b1, 32'h0, 32'h0, rc, rv);
      n_tests++; if (rv !== ref_mem[i][0]) begin n_fail++; $display("FAIL err_ram_w0[%0d]: got %h exp %h", i, rv, ref_mem[i][0]); end
      do_access(i, 1'b1, 32'h10, 32'h0, rc, rv);
      n_tests++; if (rv !== ref_mem[i][4]) begin n_fail++; $display("FAIL err_ram_w4[%0d]: got %h exp %h", i, rv, ref_mem[i][4]); end
      n_tests++; if (get_err(i) !== 1'b1) begin n_fail++; $display("FAIL err_sticky[%0d]: got %b exp 1", i, get_err(i)); end
    end
  endtask

  task automatic test_reset_mid_store();
    int rc; logic [31:0] rv, nv;
    nv = 32'h8000_0000 | $urandom;
    do_access(1, 1'b0, 32'h30, nv, rc, rv);
    ref_mem[1][12] = nv;
    mem_r[1] = 1'b1; rd_r[1] = 1'b0; addr_r[1] = 32'h30; wdat_r[1] = ~nv;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdy[%0d]: got %b exp 0", k, rdy3); end
      @(posedge clk); #1;
    end
    rd_r[1] = 1'b1;
    @(negedge clk);
    n_tests++; if (!(data3 === 32'bz || data3 === 32'h0)) begin n_fail++; $display("FAIL rstmid_hiz: got %h exp z", data3); end
    n_tests++; if (gpio0 !== 32'h0) begin n_fail++; $display("FAIL rstmid_gpio: got %h exp 0", gpio0); end
    n_tests++; if (err0 !== 1'b0 || err3 !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b/%b exp 0/0", err0, err3); end
    @(posedge clk); #1;
    rst = 1'b0; mem_r[1] = 1'b0; rd_r[1] = 1'b0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    do_access(0, 1'b1, 32'hFFFF_FFF0, 32'h0, rc, rv);
    n_tests++; if (rv !== 32'h0) begin n_fail++; $display("FAIL rstmid_cycles: got %0d exp 0", rv); end
    n_tests++; if (err0 !== exp_err[0]) begin n_fail++; $display("FAIL rstmid_cycles_err: got %b exp %b", err0, exp_err[0]); end
    do_access(1, 1'b1, 32'h30, 32'h0, rc, rv);
    n_tests++; if (rc !== 3) begin n_fail++; $display("FAIL rstmid_idle: got %0d exp 3", rc); end
    n_tests++; if (rv !== nv) begin n_fail++; $display("FAIL rstmid_no_write: got %h exp %h", rv, nv); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mem_r[i] = 1'b0; rd_r[i] = 1'b0; addr_r[i] = '0; wdat_r[i] = '0; exp_err[i] = 1'b0;
    end
    test_reset();
    test_fill();
    test_single_cycle();
    test_wait_states();
    test_abort();
    test_random();
    test_mmio();
    test_errors();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
